// File: rtl/arilla_bus_arbiter.sv
// Round-robin arbiter sharing one arilla bus between the hart load/store port (r0)
// and the debug system-bus-access port (r1), with a no-hit timeout abort.
module arilla_bus_arbiter #(
   parameter int DataWidth        = 32,
   parameter int ByteAddressWidth = 32,
   parameter int ByteSize         = 8,
   parameter int TimeoutCycles    = 16,
   localparam int BytesPerWord     = DataWidth / ByteSize,
   localparam int WordAddressWidth = ByteAddressWidth - $clog2(BytesPerWord)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [WordAddressWidth-1:0] r0_address,
   input  logic [BytesPerWord-1:0]     r0_byte_enable,
   input  logic [DataWidth-1:0]        r0_data_ctp,
   input  logic                        r0_read,
   input  logic                        r0_write,
   output logic [DataWidth-1:0]        r0_data_ptc,
   output logic                        r0_available,
   output logic                        r0_intercept,
   output logic                        r0_hit,
   output logic                        r0_error,
   input  logic [WordAddressWidth-1:0] r1_address,
   input  logic [BytesPerWord-1:0]     r1_byte_enable,
   input  logic [DataWidth-1:0]        r1_data_ctp,
   input  logic                        r1_read,
   input  logic                        r1_write,
   output logic [DataWidth-1:0]        r1_data_ptc,
   output logic                        r1_available,
   output logic                        r1_intercept,
   output logic                        r1_hit,
   output logic                        r1_error,
   output logic [WordAddressWidth-1:0] bus_address,
   output logic [BytesPerWord-1:0]     bus_byte_enable,
   output logic [DataWidth-1:0]        bus_data_ctp,
   output logic                        bus_read,
   output logic                        bus_write,
   input  logic [DataWidth-1:0]        bus_data_ptc,
   input  logic                        bus_available,
   input  logic                        bus_intercept,
   input  logic                        bus_hit,
   output logic [1:0]                  dbg_state,
   output logic                        dbg_last_grant
);

   localparam int CountWidth = $clog2(TimeoutCycles);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } state_t;

   state_t                state, state_next;
   logic                  last_grant, last_grant_next;
   logic [CountWidth-1:0] count, count_next;

   // Handshake: a requester raises read or write and holds address, byte_enable,
   // data and strobe stable until it sees available for exactly one cycle; error,
   // when set, accompanies that same available cycle and means the transfer aborted.
   logic                        gsel;
   logic                        sel_pending;
   logic                        timeout_hit;
   logic [WordAddressWidth-1:0] sel_address;
   logic [BytesPerWord-1:0]     sel_byte_enable;
   logic [DataWidth-1:0]        sel_data_ctp;
   logic                        sel_read, sel_write;
   logic [DataWidth-1:0]        resp_data;
   logic                        resp_available, resp_intercept, resp_hit, resp_error;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         count      <= '0;
      end else begin
         state      <= state_next;
         last_grant <= last_grant_next;
         count      <= count_next;
      end
   end

   assign gsel            = (state == GRANT1);
   assign sel_address     = gsel ? r1_address     : r0_address;
   assign sel_byte_enable = gsel ? r1_byte_enable : r0_byte_enable;
   assign sel_data_ctp    = gsel ? r1_data_ctp    : r0_data_ctp;
   assign sel_read        = gsel ? r1_read        : r0_read;
   assign sel_write       = gsel ? r1_write       : r0_write;
   assign sel_pending     = sel_read | sel_write;
   assign timeout_hit     = !bus_hit && (count == CountWidth'(TimeoutCycles - 1));

   always_comb begin
      state_next      = state;
      last_grant_next = last_grant;
      count_next      = count;
      bus_address     = '0;
      bus_byte_enable = '0;
      bus_data_ctp    = '0;
      bus_read        = 1'b0;
      bus_write       = 1'b0;
      resp_data       = '0;
      resp_available  = 1'b0;
      resp_intercept  = 1'b0;
      resp_hit        = 1'b0;
      resp_error      = 1'b0;
      case (state)
         IDLE: begin
            count_next = '0;
            if ((r0_read | r0_write) && (r1_read | r1_write))
               state_next = last_grant ? GRANT0 : GRANT1;
            else if (r0_read | r0_write)
               state_next = GRANT0;
            else if (r1_read | r1_write)
               state_next = GRANT1;
         end
         GRANT0, GRANT1: begin
            bus_address     = sel_address;
            bus_byte_enable = sel_byte_enable;
            bus_data_ctp    = sel_data_ctp;
            bus_read        = sel_read;
            bus_write       = sel_write;
            resp_data       = bus_data_ptc;
            resp_available  = bus_available;
            resp_intercept  = bus_intercept;
            resp_hit        = bus_hit;
            count_next      = bus_hit ? '0 : count + CountWidth'(1);
            if (!sel_pending) begin
               // Withdrawal is not a completion, so fairness history is kept.
               state_next = IDLE;
               count_next = '0;
            end else if (timeout_hit) begin
               bus_read        = 1'b0;
               bus_write       = 1'b0;
               resp_available  = 1'b1;
               resp_error      = 1'b1;
               resp_data       = '0;
               last_grant_next = gsel;
               state_next      = IDLE;
               count_next      = '0;
            end else if (bus_available) begin
               last_grant_next = gsel;
               state_next      = IDLE;
               count_next      = '0;
            end
         end
         default: begin
            state_next = IDLE;
            count_next = '0;
         end
      endcase
   end

   always_comb begin
      r0_data_ptc  = (state == GRANT0) ? resp_data      : '0;
      r0_available = (state == GRANT0) ? resp_available : 1'b0;
      r0_intercept = (state == GRANT0) ? resp_intercept : 1'b0;
      r0_hit       = (state == GRANT0) ? resp_hit       : 1'b0;
      r0_error     = (state == GRANT0) ? resp_error     : 1'b0;
      r1_data_ptc  = (state == GRANT1) ? resp_data      : '0;
      r1_available = (state == GRANT1) ? resp_available : 1'b0;
      r1_intercept = (state == GRANT1) ? resp_intercept : 1'b0;
      r1_hit       = (state == GRANT1) ? resp_hit       : 1'b0;
      r1_error     = (state == GRANT1) ? resp_error     : 1'b0;
   end

   assign dbg_state      = state;
   assign dbg_last_grant = last_grant;

endmodule

// File: tb/tb_arilla_bus_arbiter.sv
// Directed bench for arilla_bus_arbiter: reset, single read, timeout, long wait,
// round-robin alternation, reset mid-grant and requester withdrawal.
module tb_arilla_bus_arbiter;

   localparam int DW  = 32;
   localparam int WAW = 30;
   localparam int BPW = 4;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_G0   = 2'd1;
   localparam logic [1:0] S_G1   = 2'd2;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [WAW-1:0] r0_address = '0, r1_address = '0;
   logic [BPW-1:0] r0_byte_enable = '0, r1_byte_enable = '0;
   logic [DW-1:0]  r0_data_ctp = '0, r1_data_ctp = '0;
   logic           r0_read = 1'b0, r0_write = 1'b0, r1_read = 1'b0, r1_write = 1'b0;
   logic [DW-1:0]  r0_data_ptc, r1_data_ptc;
   logic           r0_available, r0_intercept, r0_hit, r0_error;
   logic           r1_available, r1_intercept, r1_hit, r1_error;
   logic [WAW-1:0] bus_address;
   logic [BPW-1:0] bus_byte_enable;
   logic [DW-1:0]  bus_data_ctp;
   logic           bus_read, bus_write;
   logic [DW-1:0]  bus_data_ptc = '0;
   logic           bus_available = 1'b0, bus_intercept = 1'b0, bus_hit = 1'b0;
   logic [1:0]     dbg_state;
   logic           dbg_last_grant;

   int checks = 0;
   int errors = 0;

   arilla_bus_arbiter #(.DataWidth(32), .ByteAddressWidth(32), .ByteSize(8), .TimeoutCycles(16)) dut (
      .clk(clk), .rst(rst),
      .r0_address(r0_address), .r0_byte_enable(r0_byte_enable), .r0_data_ctp(r0_data_ctp),
      .r0_read(r0_read), .r0_write(r0_write), .r0_data_ptc(r0_data_ptc),
      .r0_available(r0_available), .r0_intercept(r0_intercept), .r0_hit(r0_hit), .r0_error(r0_error),
      .r1_address(r1_address), .r1_byte_enable(r1_byte_enable), .r1_data_ctp(r1_data_ctp),
      .r1_read(r1_read), .r1_write(r1_write), .r1_data_ptc(r1_data_ptc),
      .r1_available(r1_available), .r1_intercept(r1_intercept), .r1_hit(r1_hit), .r1_error(r1_error),
      .bus_address(bus_address), .bus_byte_enable(bus_byte_enable), .bus_data_ctp(bus_data_ctp),
      .bus_read(bus_read), .bus_write(bus_write), .bus_data_ptc(bus_data_ptc),
      .bus_available(bus_available), .bus_intercept(bus_intercept), .bus_hit(bus_hit),
      .dbg_state(dbg_state), .dbg_last_grant(dbg_last_grant)
   );

   always #5 clk = ~clk;

   // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      next_cycle();
      next_cycle();
      mid();
      checks++;
      if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", dbg_state, S_IDLE); end
      checks++;
      if (dbg_last_grant !== 1'b1) begin errors++; $display("FAIL reset_last_grant got %b exp 1", dbg_last_grant); end
      checks++;
      if ({bus_read, bus_write, r0_available, r1_available, r0_error, r1_error} !== 6'b0) begin
         errors++; $display("FAIL reset_outputs got %b exp 000000", {bus_read, bus_write, r0_available, r1_available, r0_error, r1_error});
      end
      checks++;
      if ({bus_address, bus_data_ctp} !== '0) begin errors++; $display("FAIL reset_bus got %h exp 0", {bus_address, bus_data_ctp}); end
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic test_single_read();
      r0_read = 1'b1; r0_address = 30'h123; r0_byte_enable = 4'hF;
      bus_hit = 1'b1; bus_available = 1'b0;
      mid();
      checks++;
      if (bus_read !== 1'b0) begin errors++; $display("FAIL single_t_bus_read got %b exp 0", bus_read); end
      next_cycle();
      mid();
      checks++;
      if (bus_read !== 1'b1 || bus_address !== 30'h123 || bus_byte_enable !== 4'hF) begin
         errors++; $display("FAIL single_t1_bus got rd=%b addr=%h be=%h exp rd=1 addr=123 be=f", bus_read, bus_address, bus_byte_enable);
      end
      checks++;
      if (r0_available !== 1'b0) begin errors++; $display("FAIL single_t1_avail got %b exp 0", r0_available); end
      next_cycle();
      bus_available = 1'b1; bus_data_ptc = 32'hDEADBEEF;
      mid();
      checks++;
      if (r0_available !== 1'b1 || r0_data_ptc !== 32'hDEADBEEF) begin
         errors++; $display("FAIL single_t2_resp got av=%b data=%h exp av=1 data=deadbeef", r0_available, r0_data_ptc);
      end
      checks++;
      if ({r1_available, r1_hit, r1_intercept, r1_error} !== 4'b0 || r1_data_ptc !== '0) begin
         errors++; $display("FAIL single_r1_quiet got %b/%h exp 0000/0", {r1_available, r1_hit, r1_intercept, r1_error}, r1_data_ptc);
      end
      next_cycle();
      r0_read = 1'b0; bus_available = 1'b0; bus_data_ptc = '0;
      mid();
      checks++;
      if (dbg_state !== S_IDLE || dbg_last_grant !== 1'b0) begin
         errors++; $display("FAIL single_done got st=%0d lg=%b exp st=0 lg=0", dbg_state, dbg_last_grant);
      end
   endtask

   task automatic test_timeout();
      next_cycle();
      r1_write = 1'b1; r1_address = 30'h3FFF_FFFF; r1_data_ctp = 32'hCAFE0001;
      bus_hit = 1'b0; bus_available = 1'b0; bus_data_ptc = 32'h55;
      mid();
      for (int k = 1; k <= 16; k++) begin
         next_cycle();
         mid();
         if (k < 16) begin
            checks++;
            if (bus_write !== 1'b1 || r1_available !== 1'b0 || r1_error !== 1'b0) begin
               errors++; $display("FAIL timeout_wait k=%0d got wr=%b av=%b er=%b exp 1 0 0", k, bus_write, r1_available, r1_error);
            end
         end else begin
            checks++;
            if (bus_write !== 1'b0 || r1_available !== 1'b1 || r1_error !== 1'b1 || r1_data_ptc !== '0) begin
               errors++; $display("FAIL timeout_fire got wr=%b av=%b er=%b d=%h exp 0 1 1 0", bus_write, r1_available, r1_error, r1_data_ptc);
            end
         end
      end
      next_cycle();
      r1_write = 1'b0; bus_data_ptc = '0;
      mid();
      checks++;
      if (dbg_state !== S_IDLE || dbg_last_grant !== 1'b1 || r1_error !== 1'b0) begin
         errors++; $display("FAIL timeout_after got st=%0d lg=%b er=%b exp 0 1 0", dbg_state, dbg_last_grant, r1_error);
      end
   endtask

   task automatic test_long_wait();
      next_cycle();
      r0_read = 1'b1; r0_address = 30'h40;
      bus_hit = 1'b1; bus_intercept = 1'b1; bus_available = 1'b0;
      mid();
      for (int k = 1; k <= 40; k++) begin
         next_cycle();
         if (k == 40) begin bus_available = 1'b1; bus_data_ptc = 32'h12345678; end
         mid();
         if (k == 1) begin
            checks++;
            if (r0_intercept !== 1'b1 || r0_hit !== 1'b1 || r1_intercept !== 1'b0) begin
               errors++; $display("FAIL long_intercept got r0i=%b r0h=%b r1i=%b exp 1 1 0", r0_intercept, r0_hit, r1_intercept);
            end
         end
         if (k < 40) begin
            checks++;
            if (r0_available !== 1'b0 || r0_error !== 1'b0) begin
               errors++; $display("FAIL long_wait k=%0d got av=%b er=%b exp 0 0", k, r0_available, r0_error);
            end
         end else begin
            checks++;
            if (r0_available !== 1'b1 || r0_error !== 1'b0 || r0_data_ptc !== 32'h12345678) begin
               errors++; $display("FAIL long_done got av=%b er=%b d=%h exp 1 0 12345678", r0_available, r0_error, r0_data_ptc);
            end
         end
      end
      next_cycle();
      r0_read = 1'b0; bus_available = 1'b0; bus_intercept = 1'b0; bus_data_ptc = '0;
      mid();
      checks++;
      if (dbg_state !== S_IDLE || dbg_last_grant !== 1'b0) begin
         errors++; $display("FAIL long_after got st=%0d lg=%b exp 0 0", dbg_state, dbg_last_grant);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_st [10];
      logic       r1_req [10];
      logic       exp_av0 [10];
      logic       exp_av1 [10];
      exp_st  = '{S_IDLE, S_G0, S_IDLE, S_G1, S_IDLE, S_G0, S_IDLE, S_G1, S_IDLE, S_G0};
      r1_req  = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
      exp_av0 = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
      exp_av1 = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
      next_cycle();
      rst = 1'b1;
      mid();
      r0_data_ctp = 32'hA0A0A0A0; r1_data_ctp = 32'hB1B1B1B1;
      for (int c = 0; c < 10; c++) begin
         next_cycle();
         rst = 1'b0;
         r0_write = 1'b1; r1_write = r1_req[c];
         bus_available = 1'b1; bus_hit = 1'b1;
         mid();
         checks++;
         if (dbg_state !== exp_st[c] || r0_available !== exp_av0[c] || r1_available !== exp_av1[c]) begin
            errors++; $display("FAIL rr c=%0d got st=%0d av0=%b av1=%b exp st=%0d av0=%b av1=%b",
                               c, dbg_state, r0_available, r1_available, exp_st[c], exp_av0[c], exp_av1[c]);
         end
         if (exp_st[c] == S_G1) begin
            checks++;
            if (bus_data_ctp !== 32'hB1B1B1B1) begin errors++; $display("FAIL rr_data1 c=%0d got %h exp b1b1b1b1", c, bus_data_ctp); end
         end else if (exp_st[c] == S_G0) begin
            checks++;
            if (bus_data_ctp !== 32'hA0A0A0A0) begin errors++; $display("FAIL rr_data0 c=%0d got %h exp a0a0a0a0", c, bus_data_ctp); end
         end else begin
            checks++;
            if (bus_write !== 1'b0 || bus_data_ctp !== '0) begin errors++; $display("FAIL rr_idle c=%0d got wr=%b d=%h exp 0 0", c, bus_write, bus_data_ctp); end
         end
      end
      next_cycle();
      r0_write = 1'b0; r1_write = 1'b0; bus_available = 1'b0;
      mid();
      checks++;
      if (dbg_state !== S_IDLE || dbg_last_grant !== 1'b0) begin
         errors++; $display("FAIL rr_after got st=%0d lg=%b exp 0 0", dbg_state, dbg_last_grant);
      end
   endtask

   task automatic test_reset_mid_grant();
      next_cycle();
      r1_write = 1'b1; bus_hit = 1'b1; bus_available = 1'b0;
      mid();
      next_cycle();
      mid();
      checks++;
      if (dbg_state !== S_G1 || bus_write !== 1'b1) begin errors++; $display("FAIL rstmid_grant got st=%0d wr=%b exp 2 1", dbg_state, bus_write); end
      next_cycle();
      rst = 1'b1;
      mid();
      next_cycle();
      rst = 1'b0; r0_read = 1'b1;
      mid();
      checks++;
      if (dbg_state !== S_IDLE || bus_write !== 1'b0 || dbg_last_grant !== 1'b1 || r1_available !== 1'b0 || r1_error !== 1'b0) begin
         errors++; $display("FAIL rstmid_after got st=%0d wr=%b lg=%b av=%b er=%b exp 0 0 1 0 0",
                            dbg_state, bus_write, dbg_last_grant, r1_available, r1_error);
      end
      next_cycle();
      bus_available = 1'b1;
      mid();
      checks++;
      if (dbg_state !== S_G0 || bus_read !== 1'b1 || r0_available !== 1'b1 || r1_available !== 1'b0) begin
         errors++; $display("FAIL rstmid_tie got st=%0d rd=%b av0=%b av1=%b exp 1 1 1 0", dbg_state, bus_read, r0_available, r1_available);
      end
      next_cycle();
      r0_read = 1'b0; bus_available = 1'b0;
      mid();
      next_cycle();
      bus_available = 1'b1;
      mid();
      checks++;
      if (dbg_state !== S_G1 || r1_available !== 1'b1) begin errors++; $display("FAIL rstmid_r1 got st=%0d av1=%b exp 2 1", dbg_state, r1_available); end
      next_cycle();
      r1_write = 1'b0; bus_available = 1'b0;
      mid();
   endtask

   task automatic test_withdraw();
      next_cycle();
      r0_read = 1'b1; r1_read = 1'b1; r0_address = 30'h111; r1_address = 30'h222;
      bus_hit = 1'b1; bus_available = 1'b0;
      mid();
      next_cycle();
      mid();
      checks++;
      if (dbg_state !== S_G0 || bus_address !== 30'h111) begin errors++; $display("FAIL wd_grant got st=%0d a=%h exp 1 111", dbg_state, bus_address); end
      next_cycle();
      r0_read = 1'b0;
      mid();
      checks++;
      if (bus_read !== 1'b0 || r0_available !== 1'b0) begin errors++; $display("FAIL wd_drop got rd=%b av=%b exp 0 0", bus_read, r0_available); end
      next_cycle();
      mid();
      checks++;
      if (dbg_state !== S_IDLE || dbg_last_grant !== 1'b1) begin errors++; $display("FAIL wd_idle got st=%0d lg=%b exp 0 1", dbg_state, dbg_last_grant); end
      next_cycle();
      bus_available = 1'b1;
      mid();
      checks++;
      if (dbg_state !== S_G1 || bus_address !== 30'h222 || r1_available !== 1'b1 || r0_available !== 1'b0) begin
         errors++; $display("FAIL wd_r1 got st=%0d a=%h av1=%b av0=%b exp 2 222 1 0", dbg_state, bus_address, r1_available, r0_available);
      end
      next_cycle();
      r1_read = 1'b0; bus_available = 1'b0;
      mid();
      checks++;
      if (dbg_state !== S_IDLE || dbg_last_grant !== 1'b1) begin errors++; $display("FAIL wd_after got st=%0d lg=%b exp 0 1", dbg_state, dbg_last_grant); end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_timeout();
      test_long_wait();
      test_back_to_back();
      test_reset_mid_grant();
      test_withdraw();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/arilla_bus_arbiter.md
# arilla_bus_arbiter

Two-requester arbiter that shares one downstream arilla bus between the hart load/store port (requester 0) and the debug module system-bus-access port (requester 1). It owns the grant, holds it for the full duration of a transfer, and steers responses back only to the granted side. It uses round-robin arbitration and aborts, with an error, any transfer that no peripheral decodes.

## Interface
Parameters:
- DataWidth, 32, bus data width in bits.
- ByteAddressWidth, 32, byte address width; word address width is ByteAddressWidth - clog2(DataWidth/ByteSize).
- ByteSize, 8, bits per byte-enable lane.
- TimeoutCycles, 16, maximum granted cycles with hit low before abort; minimum 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- rN_address / rN_byte_enable / rN_data_ctp / rN_read / rN_write  in  WordAddressWidth / BytesPerWord / DataWidth / 1 / 1  request from requester N (N = 0, 1).
- rN_data_ptc  out  DataWidth  read data to requester N.
- rN_available  out  1  transfer completion strobe to requester N.
- rN_intercept  out  1  downstream intercept, forwarded while N is granted.
- rN_hit  out  1  downstream hit, forwarded while N is granted.
- rN_error  out  1  single-cycle strobe: transfer aborted by timeout.
- bus_address / bus_byte_enable / bus_data_ctp / bus_read / bus_write  out  as above  shared downstream request.
- bus_data_ptc / bus_available / bus_intercept / bus_hit  in  as above  shared downstream response; bus_hit reads 0 when undriven.

## Operation
- State machine:
  - IDLE: no requester granted.
  - GRANT0: requester 0 owns the bus.
  - GRANT1: requester 1 owns the bus.
- A requester is pending when its read or write is high. Asserting both read and write at once is illegal and is forwarded unchanged.
- IDLE transitions:
  - Only one pending: grant it.
  - Both pending: grant the requester that is not last_grant.
  - last_grant resets to 1, so requester 0 wins the first tie.
- GRANTn:
  - bus_* outputs are driven from requester n.
  - bus_available, bus_data_ptc, bus_intercept and bus_hit are routed to requester n.
  - The non-granted requester sees available, hit, intercept and error at 0 and data_ptc at 0.
- Completion: bus_available high while the granted requester's read or write is high.
  - Effects: last_grant <= n, timeout counter cleared, next state IDLE.
- Requester withdraws (read and write both low) while granted: return to IDLE with no completion. last_grant is not updated.
- Timeout:
  - The counter increments on each granted cycle with bus_hit low and clears on any cycle with bus_hit high.
  - When the count reaches TimeoutCycles-1 and bus_hit is still low, that cycle drives rN_available=1, rN_error=1, rN_data_ptc=0.
  - Effects: bus_read and bus_write are forced to 0 in that cycle, last_grant <= n, next state IDLE.
- In IDLE, bus_read, bus_write, bus_address, bus_byte_enable and bus_data_ctp are all 0.
- Requesters hold address, byte_enable, data and strobe stable until they see available.

## Timing
- Reset values: state IDLE, last_grant=1, counter 0, all outputs 0.
- Arbitration latency is 1 cycle:
  - Request seen in IDLE in cycle t.
  - bus_read or bus_write is asserted in cycle t+1.
  - Earliest rN_available is in cycle t+1, if the peripheral completes in the same cycle.
- Response paths (bus_* to rN_*) are combinational within the granted cycle.
- Back-to-back: after completion the arbiter spends 1 IDLE cycle, so minimum transfer spacing is 2 cycles. A requester held high continuously alternates fairly with the other.
- A new request arriving in the same cycle as the other requester's completion is arbitrated in the following IDLE cycle.
- rst asserted mid-transfer: next cycle is IDLE with all outputs 0. No available or error is produced for the aborted transfer.
- rN_error is high for exactly one cycle and always coincides with rN_available.

## Test plan
- Single read, r0 only, peripheral completes with bus_available=1, bus_data_ptc=0xDEADBEEF in the 2nd granted cycle:
  - Bus read seen at t+1.
  - r0_available=1 and r0_data_ptc=0xDEADBEEF at t+2.
  - r1_* outputs stay 0.
- Simultaneous r0 and r1 writes, held continuously after reset: grants go 0, 1, 0, 1, with one IDLE cycle between each completion.
- r1 write to an unmapped address (bus_hit stays 0), TimeoutCycles=16: r1_available=1, r1_error=1 in the 16th granted cycle, bus_write=0 in that cycle, then IDLE.
- Hit high but bus_available delayed 40 cycles: no timeout; completion at cycle 40 with r0_error=0.
- rst pulsed while in GRANT1: state is IDLE, bus_write=0 and last_grant=1 on the next cycle; a following r0/r1 tie grants r0.
- r0 withdraws its request while granted with r1 pending: returns to IDLE; r1 is granted next, with last_grant unchanged.
